hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Tracks the destination registers of instructions in flight in the EX, MEM and WB stages of the five-stage pipeline. It is the consumer of the `WriteReg`/`RegWrite` pair produced at decode. Each cycle it compares the decode-stage source registers (`rs`, `rt`) against the in-flight destinations and produces per-operand forwarding selects and a load-use stall. It sits between the ID stage and the ID/EX pipeline register and controls the PC/IF-ID write enables.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.

Ports:
- `CLK`, input, 1: pipeline clock, rising edge.
- `Reset`, input, 1: asynchronous, active-high; clears all tracking state.
- `rs`, input, REG_AW: ID-stage source register A.
- `rt`, input, REG_AW: ID-stage source register B.
- `UseRs`, input, 1: ID instruction reads `rs`.
- `UseRt`, input, 1: ID instruction reads `rt`.
- `WriteReg`, input, REG_AW: ID instruction destination, already resolved to rt, rd or 31.
- `RegWrite`, input, 1: ID instruction writes `WriteReg`.
- `MemRead`, input, 1: ID instruction is a load.
- `Flush`, input, 1: ID instruction is squashed (taken branch/jump); treat it as a bubble.
- `ForwardA`, output, 2: operand A source. 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.
- `ForwardB`, output, 2: operand B source, same encoding as `ForwardA`.
- `Stall`, output, 1: hold PC and IF/ID, and insert a bubble into EX.

## Operation
Tracking state is three entries, `E` (EX), `M` (MEM) and `W` (WB). Each entry holds `{valid, reg[REG_AW-1:0], load}`.

On every rising edge of `CLK` with `Reset` low:
- `W <= M` and `M <= E`. This shift happens unconditionally.
- `E` gets `{RegWrite & (WriteReg != 0), WriteReg, MemRead}` when `Stall == 0` and `Flush == 0`.
- Otherwise `E` gets a bubble `{0, 0, 0}`.

Source X (rs or rt) matches entry S when all of the following hold: `UseX`, `X != 0`, `S.valid`, and `S.reg == X`.

`ForwardX` uses a priority select, youngest first:
- E match → 01
- else M match → 10
- else W match → 11
- else → 00

`Stall` = (E match on rs or rt) AND `E.load`. In that case `ForwardA/B` still report their computed values; the ID/EX stage ignores them because the bubble is inserted.

Register 0 never matches, never stalls and never becomes valid in any entry.

`Flush` together with `Stall` in the same cycle: a bubble is inserted. The stall releases on the next cycle because the load has moved to M.

`Stall` lasts exactly one cycle per load-use hazard. After the shift, the load sits in M and the consumer gets `Forward` = 10.

## Timing
- `ForwardA`, `ForwardB` and `Stall` are combinational from the entry state and the current ID inputs. There are no registered outputs. Zero-cycle latency.
- State update latency is one cycle: an instruction issued at edge n appears in E after n, in M after n+1, and in W after n+2. It is gone after n+3.
- Asynchronous `Reset` clears all entries immediately. While `Reset` is high and after it deasserts, outputs are `ForwardA = 00`, `ForwardB = 00`, `Stall = 0` until an instruction is issued.
- Reset asserted mid-stall drops `Stall` to 0 within the same cycle, without waiting for an edge.
- Back-to-back writers to the same register: the youngest entry wins the forward.

## Configuration
- `HAZARD_FORWARD_EN`, defined: behaviour as above. Only load-use hazards stall.
- `HAZARD_FORWARD_EN`, undefined:
  - `ForwardA` and `ForwardB` are tied to 00.
  - `Stall` = any match on rs or rt against E or M. Loads and ALU results are treated alike.
  - A W match does not stall, because the register file writes in the first half-cycle.
  - Each stall inserts one bubble per cycle until no match remains.

## Test plan
- Reset with `Reset` pulsed mid-cycle and stale entries present → all outputs 0 immediately; after release, `rs = 8` with `UseRs = 1` → `ForwardA = 00`.
- Issue `add $8`, then a consumer with `rs = 8` next cycle → `ForwardA = 01`, `Stall = 0`. The same consumer issued 2 cycles later → 10; 3 cycles later → 11; 4 cycles later → 00.
- Issue `lw $9`, then a consumer with `rt = 9` → `Stall = 1` for exactly one cycle. The next cycle gives `ForwardB = 10`, `Stall = 0`.
- Writer to `$0` (`RegWrite = 1`, `WriteReg = 0`), then a consumer with `rs = 0` → `ForwardA = 00`, `Stall = 0`.
- `lw $5` issued with `Flush = 1`, then a consumer with `rs = 5` → no stall, `ForwardA = 00`. Also check that two writers to `$3` issued back to back → `ForwardA = 01` (youngest wins).
- With `HAZARD_FORWARD_EN` undefined: `add $4`, then a consumer with `rs = 4` → `Stall = 1` for 2 cycles, then 0, with `ForwardA = 00` throughout.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the ID-stage operand/destination description presented to the
//   hazard scoreboard together with the forwarding selects and stall it
//   returns.
//   master : ID stage drives rs/rt/UseRs/UseRt/WriteReg/RegWrite/MemRead/Flush,
//            and receives ForwardA/ForwardB/Stall.
//   slave  : scoreboard side, the mirror image.
//   REG_AW must match the REG_AW of the scoreboard it connects to.
interface hazard_scoreboard_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              UseRs;
    logic              UseRt;
    logic [REG_AW-1:0] WriteReg;
    logic              RegWrite;
    logic              MemRead;
    logic              Flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              Stall;

    modport master (
        output rs, rt, UseRs, UseRt, WriteReg, RegWrite, MemRead, Flush,
        input  ForwardA, ForwardB, Stall
    );

    modport slave (
        input  rs, rt, UseRs, UseRt, WriteReg, RegWrite, MemRead, Flush,
        output ForwardA, ForwardB, Stall
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks destination registers of instructions in EX/MEM/WB and, each cycle,
//   compares the ID-stage sources against them to produce forwarding selects
//   and a stall that holds PC and IF/ID while a bubble enters EX.
//   Ports:
//     CLK   : pipeline clock, rising edge
//     Reset : asynchronous, active-high; clears all tracking entries
//     bus   : hazard_scoreboard_if.slave (ID inputs in, ForwardA/B + Stall out)
//   Build option:
//     HAZARD_FORWARD_EN defined   : full forwarding, only load-use stalls.
//     HAZARD_FORWARD_EN undefined : no forwarding (selects tied to 00); any
//                                   EX or MEM match stalls until it retires.
//   Outputs are purely combinational from the entries and current ID inputs.
module hazard_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    hazard_scoreboard_if.slave bus
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
`ifdef HAZARD_FORWARD_EN
        logic              ld;
`endif
    } ent_t;

    ent_t ent_e, ent_m;
`ifdef HAZARD_FORWARD_EN
    ent_t ent_w;
`endif
    logic stall;

    // Entries only become valid for non-zero destinations, but the x != 0
    // term still guards against a stale register-0 compare.
    function automatic logic hit(input logic use_x, input logic [REG_AW-1:0] x,
                                 input ent_t s);
        return use_x && (x != '0) && s.vld && (s.rd == x);
    endfunction

    logic e_a, e_b, m_a, m_b;
    assign e_a = hit(bus.UseRs, bus.rs, ent_e);
    assign e_b = hit(bus.UseRt, bus.rt, ent_e);
    assign m_a = hit(bus.UseRs, bus.rs, ent_m);
    assign m_b = hit(bus.UseRt, bus.rt, ent_m);

`ifdef HAZARD_FORWARD_EN
    logic w_a, w_b;
    assign w_a = hit(bus.UseRs, bus.rs, ent_w);
    assign w_b = hit(bus.UseRt, bus.rt, ent_w);

    // Youngest producer wins.
    assign bus.ForwardA = e_a ? 2'b01 : m_a ? 2'b10 : w_a ? 2'b11 : 2'b00;
    assign bus.ForwardB = e_b ? 2'b01 : m_b ? 2'b10 : w_b ? 2'b11 : 2'b00;
    // Only a load in EX cannot be forwarded in time; one bubble moves it to MEM.
    assign stall = (e_a || e_b) && ent_e.ld;
`else
    assign bus.ForwardA = 2'b00;
    assign bus.ForwardB = 2'b00;
    // WB needs no stall: the register file writes in the first half-cycle.
    assign stall = e_a || e_b || m_a || m_b;
`endif

    assign bus.Stall = stall;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ent_e <= '0;
            ent_m <= '0;
`ifdef HAZARD_FORWARD_EN
            ent_w <= '0;
`endif
        end else begin
            ent_m <= ent_e;
`ifdef HAZARD_FORWARD_EN
            ent_w <= ent_m;
`endif
            if (!stall && !bus.Flush) begin
                ent_e.vld <= bus.RegWrite && (bus.WriteReg != '0);
                ent_e.rd  <= bus.WriteReg;
`ifdef HAZARD_FORWARD_EN
                ent_e.ld  <= bus.MemRead;
`endif
            end else begin
                ent_e <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   npass = 0;
    int   ntot  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5)) bus ();

    hazard_scoreboard #(.REG_AW(5)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic drive(input logic urs, input logic [4:0] s, input logic urt,
                         input logic [4:0] t, input logic rw, input logic [4:0] wr,
                         input logic mr, input logic fl);
        bus.UseRs = urs; bus.rs = s; bus.UseRt = urt; bus.rt = t;
        bus.RegWrite = rw; bus.WriteReg = wr; bus.MemRead = mr; bus.Flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        idle();
        #2;
        ntot++;
        if ({bus.ForwardA, bus.ForwardB, bus.Stall} !== 5'b0)
            $display("FAIL reset_held got fa=%b fb=%b st=%b want 0", bus.ForwardA, bus.ForwardB, bus.Stall);
        else npass++;
        step();
        rst = 1'b0;
        step();
        // lw $7 leaves a stale load in E
        drive(0, 0, 0, 0, 1, 7, 1, 0);
        step();
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        #1;
        ntot++;
        if (bus.Stall !== 1'b1) $display("FAIL reset_pre_stall got %b want 1", bus.Stall);
        else npass++;
        rst = 1'b1;
        #1;
        ntot++;
        if ({bus.ForwardA, bus.Stall} !== 3'b0)
            $display("FAIL reset_mid got fa=%b st=%b want 00/0", bus.ForwardA, bus.Stall);
        else npass++;
        rst = 1'b0;
        #1;
        ntot++;
        if ({bus.ForwardA, bus.Stall} !== 3'b0)
            $display("FAIL reset_release got fa=%b st=%b want 00/0", bus.ForwardA, bus.Stall);
        else npass++;
        drive(1, 8, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ntot++;
        if ({bus.ForwardA, bus.Stall} !== 3'b0)
            $display("FAIL reset_rs8 got fa=%b st=%b want 00/0", bus.ForwardA, bus.Stall);
        else npass++;
        step();
    endtask

    task automatic test_distance();
        logic [1:0] fa_exp [1:4];
        logic       st_exp [1:4];
        fa_exp[1] = FWD ? 2'b01 : 2'b00; st_exp[1] = !FWD;
        fa_exp[2] = FWD ? 2'b10 : 2'b00; st_exp[2] = !FWD;
        fa_exp[3] = FWD ? 2'b11 : 2'b00; st_exp[3] = 1'b0;
        fa_exp[4] = 2'b00;               st_exp[4] = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            drain();
            drive(0, 0, 0, 0, 1, 8, 0, 0);   // add $8
            step();
            idle();
            repeat (d - 1) step();
            drive(1, 8, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            ntot++;
            if (bus.ForwardA !== fa_exp[d] || bus.Stall !== st_exp[d])
                $display("FAIL dist%0d got fa=%b st=%b want fa=%b st=%b",
                         d, bus.ForwardA, bus.Stall, fa_exp[d], st_exp[d]);
            else npass++;
        end
    endtask

    task automatic test_load_use();
        drain();
        drive(0, 0, 0, 0, 1, 9, 1, 0);       // lw $9
        step();
        drive(0, 0, 1, 9, 1, 10, 0, 0);      // consumer of $9, writes $10
        @(negedge clk);
        ntot++;
        if (bus.Stall !== 1'b1 || bus.ForwardB !== (FWD ? 2'b01 : 2'b00))
            $display("FAIL lu_c0 got st=%b fb=%b want st=1 fb=%b", bus.Stall, bus.ForwardB, FWD ? 2'b01 : 2'b00);
        else npass++;
        step();
        @(negedge clk);
        ntot++;
        if (bus.Stall !== !FWD || bus.ForwardB !== (FWD ? 2'b10 : 2'b00))
            $display("FAIL lu_c1 got st=%b fb=%b want st=%b fb=%b", bus.Stall, bus.ForwardB, !FWD, FWD ? 2'b10 : 2'b00);
        else npass++;
        step();
        @(negedge clk);
        ntot++;
        if (bus.Stall !== 1'b0 || bus.ForwardB !== (FWD ? 2'b11 : 2'b00))
            $display("FAIL lu_c2 got st=%b fb=%b want st=0 fb=%b", bus.Stall, bus.ForwardB, FWD ? 2'b11 : 2'b00);
        else npass++;
        step();
    endtask

    task automatic test_zero_reg();
        drain();
        drive(0, 0, 0, 0, 1, 0, 1, 0);       // load to $0
        step();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        ntot++;
        if ({bus.ForwardA, bus.ForwardB, bus.Stall} !== 5'b0)
            $display("FAIL zero_c0 got fa=%b fb=%b st=%b want 0", bus.ForwardA, bus.ForwardB, bus.Stall);
        else npass++;
        step();
        @(negedge clk);
        ntot++;
        if ({bus.ForwardA, bus.ForwardB, bus.Stall} !== 5'b0)
            $display("FAIL zero_c1 got fa=%b fb=%b st=%b want 0", bus.ForwardA, bus.ForwardB, bus.Stall);
        else npass++;
        step();
    endtask

    task automatic test_flush();
        drain();
        drive(0, 0, 0, 0, 1, 5, 1, 1);       // squashed lw $5
        step();
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ntot++;
        if (bus.ForwardA !== 2'b00 || bus.Stall !== 1'b0)
            $display("FAIL flush_c0 got fa=%b st=%b want 00/0", bus.ForwardA, bus.Stall);
        else npass++;
        step();
        @(negedge clk);
        ntot++;
        if (bus.ForwardA !== 2'b00 || bus.Stall !== 1'b0)
            $display("FAIL flush_c1 got fa=%b st=%b want 00/0", bus.ForwardA, bus.Stall);
        else npass++;
        step();
    endtask

    task automatic test_back_to_back();
        drain();
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        step();
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ntot++;
        if (bus.ForwardA !== (FWD ? 2'b01 : 2'b00) || bus.Stall !== !FWD)
            $display("FAIL b2b got fa=%b st=%b want fa=%b st=%b", bus.ForwardA, bus.Stall, FWD ? 2'b01 : 2'b00, !FWD);
        else npass++;
        drive(0, 3, 0, 0, 0, 0, 0, 0);       // rs=3 but not read
        #1;
        ntot++;
        if (bus.ForwardA !== 2'b00 || bus.Stall !== 1'b0)
            $display("FAIL b2b_nouse got fa=%b st=%b want 00/0", bus.ForwardA, bus.Stall);
        else npass++;
        step();
    endtask

    task automatic test_flush_with_stall();
        drain();
        drive(0, 0, 0, 0, 1, 6, 1, 0);       // lw $6
        step();
        drive(1, 6, 0, 0, 1, 6, 0, 1);       // flushed consumer that writes $6
        @(negedge clk);
        ntot++;
        if (bus.Stall !== 1'b1)
            $display("FAIL fs_c0 got st=%b want 1", bus.Stall);
        else npass++;
        step();
        drive(1, 6, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ntot++;
        if (bus.Stall !== !FWD || bus.ForwardA !== (FWD ? 2'b10 : 2'b00))
            $display("FAIL fs_c1 got st=%b fa=%b want st=%b fa=%b", bus.Stall, bus.ForwardA, !FWD, FWD ? 2'b10 : 2'b00);
        else npass++;
        step();
        @(negedge clk);
        ntot++;
        if (bus.Stall !== 1'b0 || bus.ForwardA !== (FWD ? 2'b11 : 2'b00))
            $display("FAIL fs_c2 got st=%b fa=%b want st=0 fa=%b", bus.Stall, bus.ForwardA, FWD ? 2'b11 : 2'b00);
        else npass++;
        step();
    endtask

    initial begin
        test_reset();
        test_distance();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_back_to_back();
        test_flush_with_stall();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
